rob_multi: RTL and testbench
============================

Name:
rob_multi

Overview:
- Parametrised reorder buffer for the out-of-order core. Successor to the single-commit ROB.
- Allocates one entry per cycle in program order and accepts results from CDB_PORTS result buses.
- Retires up to COMMIT_WIDTH completed entries per cycle, in order.
- Supports partial squash (branch mispredict) and full flush (exception). Sits between dispatch/rename, the reservation stations' CDB, and the architectural register file.

Parameters:
- TAG_WIDTH, 4, ROB tag width; DEPTH = 2**TAG_WIDTH entries.
- DATA_WIDTH, 32, result width.
- CDB_PORTS, 2, number of result broadcast buses (1..4).
- COMMIT_WIDTH, 2, maximum retirements per cycle (1..4).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- alloc_valid  in  1  dispatch requests an entry.
- alloc_rd  in  5  destination architectural register.
- alloc_pc  in  32  instruction PC.
- alloc_ready  out  1  entry available (= !full), combinational.
- alloc_tag  out  TAG_WIDTH  tag granted (= current tail), combinational.
- cdb_valid  in  CDB_PORTS  per-port result valid.
- cdb_tag  in  CDB_PORTS*TAG_WIDTH  packed result tags, port p at [p*TAG_WIDTH +: TAG_WIDTH].
- cdb_data  in  CDB_PORTS*DATA_WIDTH  packed result data.
- query_tag  in  TAG_WIDTH  operand-forwarding lookup tag.
- query_done  out  1  queried entry valid and done, combinational.
- query_data  out  DATA_WIDTH  queried entry data, combinational.
- flush  in  1  squash all entries younger than flush_tag.
- flush_tag  in  TAG_WIDTH  youngest surviving entry.
- flush_all  in  1  discard every entry.
- commit_valid  out  COMMIT_WIDTH  registered per-slot retire strobe; slot 0 is oldest.
- commit_rd  out  COMMIT_WIDTH*5  packed destination registers.
- commit_data  out  COMMIT_WIDTH*DATA_WIDTH  packed results.
- commit_pc  out  COMMIT_WIDTH*32  packed PCs.
- rob_head  out  TAG_WIDTH  oldest entry pointer.
- rob_tail  out  TAG_WIDTH  next allocation pointer.
- rob_count  out  TAG_WIDTH+1  occupied entries.
- rob_full  out  1  rob_count == DEPTH.
- rob_empty  out  1  rob_count == 0.

Behaviour:
- Entry state: valid, done, rd, pc, data.
- Reset (rst high at an edge): all entries cleared; head = tail = count = 0; commit_* = 0. rob_empty = 1, alloc_ready = 1. Reset mid-operation discards all in-flight entries with no commit.
- Allocate: when alloc_valid && alloc_ready, entry[tail] gets valid = 1, done = 0, rd, pc. Tail increments mod DEPTH. When full, alloc_valid is ignored and tail is unchanged.
- CDB write: for each port with cdb_valid, if entry[tag].valid, set done = 1 and data = cdb_data. Writes to invalid entries are ignored. On equal tags across ports, the lowest port index wins.
- Commit:
  - Slot k is eligible iff entry[head+k] is valid and done (registered state), and every slot below k is eligible.
  - Eligible slots are registered onto commit_* for exactly one cycle; those entries are invalidated and head advances by the number committed.
  - Commit latency: a CDB write at edge N gives commit_valid high after edge N+1 at the earliest.
  - rd == 0 entries commit normally; the consumer ignores the write.
- Wrap-around: head, tail and head+k are all mod DEPTH. Full vs empty is decided by count only, never by pointer equality.
- Count: count_next = count + alloc_fire − n_commit − n_squashed. Simultaneous allocate and commit when full: alloc_ready is low, so allocation is blocked that cycle even if commits free entries (no same-cycle reuse).
- Partial flush (flush = 1):
  - Entries strictly younger than flush_tag, up to tail−1, are invalidated; tail = flush_tag + 1.
  - Allocation is suppressed that cycle.
  - CDB writes to squashed tags are dropped.
  - Commit of older entries proceeds the same cycle.
  - flush_tag == tail−1 is a no-op. flush_tag must name a valid entry.
- flush_all: all entries invalidated; head = tail = count = 0; commit_valid = 0 next cycle; allocation and CDB writes suppressed. flush_all has priority over flush; flush has priority over allocate.
- query_done / query_data reflect registered state only; there is no same-cycle CDB bypass.

Test Plan:
- Reset then alloc rd=3,5 → tags 0,1, count 2. CDB tag1 = 0x28, then tag0 = 0x1E → both retire in one cycle: slot0 rd3 = 0x1E, slot1 rd5 = 0x28. Head = 2.
- Out-of-order completion: alloc 4 entries; CDB tags 3,2,1 → no commit. CDB tag0 → commits tags 0,1 next cycle, then 2,3 the following cycle.
- Fill 16 entries → rob_full = 1, alloc_ready = 0, extra alloc_valid ignored. Complete all → eight cycles of dual commit; head wraps 15→0; rob_empty = 1 at end.
- Alloc tags 0..5; flush with flush_tag = 2 and same-cycle CDB tag 4 → tail = 3, count = 3, tag 4 not marked done. Next alloc gets tag 3.
- Dual CDB ports both tag 1, data 0xAA (port 0) and 0xBB (port 1) → committed data = 0xAA.
- flush_all with 6 entries pending and head 0 done → no commit_valid; count = 0, head = tail = 0. rst mid-run gives the same result.

Source files
------------

// File: rtl/rob_multi_if.sv
// Reorder-buffer port bundle: dispatch allocation, CDB results, operand query,
// squash controls and the registered retire bus.
interface rob_multi_if #(
    parameter int TAG_WIDTH    = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int CDB_PORTS    = 2,
    parameter int COMMIT_WIDTH = 2
);
    logic                             alloc_valid;
    logic [4:0]                       alloc_rd;
    logic [31:0]                      alloc_pc;
    logic                             alloc_ready;
    logic [TAG_WIDTH-1:0]             alloc_tag;
    logic [CDB_PORTS-1:0]             cdb_valid;
    logic [CDB_PORTS*TAG_WIDTH-1:0]   cdb_tag;
    logic [CDB_PORTS*DATA_WIDTH-1:0]  cdb_data;
    logic [TAG_WIDTH-1:0]             query_tag;
    logic                             query_done;
    logic [DATA_WIDTH-1:0]            query_data;
    logic                             flush;
    logic [TAG_WIDTH-1:0]             flush_tag;
    logic                             flush_all;
    logic [COMMIT_WIDTH-1:0]          commit_valid;
    logic [COMMIT_WIDTH*5-1:0]        commit_rd;
    logic [COMMIT_WIDTH*DATA_WIDTH-1:0] commit_data;
    logic [COMMIT_WIDTH*32-1:0]       commit_pc;
    logic [TAG_WIDTH-1:0]             rob_head;
    logic [TAG_WIDTH-1:0]             rob_tail;
    logic [TAG_WIDTH:0]               rob_count;
    logic                             rob_full;
    logic                             rob_empty;

    modport slave (
        input  alloc_valid, alloc_rd, alloc_pc, cdb_valid, cdb_tag, cdb_data,
               query_tag, flush, flush_tag, flush_all,
        output alloc_ready, alloc_tag, query_done, query_data,
               commit_valid, commit_rd, commit_data, commit_pc,
               rob_head, rob_tail, rob_count, rob_full, rob_empty
    );

    modport master (
        output alloc_valid, alloc_rd, alloc_pc, cdb_valid, cdb_tag, cdb_data,
               query_tag, flush, flush_tag, flush_all,
        input  alloc_ready, alloc_tag, query_done, query_data,
               commit_valid, commit_rd, commit_data, commit_pc,
               rob_head, rob_tail, rob_count, rob_full, rob_empty
    );
endinterface

// File: rtl/rob_multi.sv
// Multi-commit reorder buffer: in-order allocate, CDB_PORTS result writes,
// up to COMMIT_WIDTH in-order retirements per cycle, partial and full squash.
module rob_multi #(
    parameter int TAG_WIDTH    = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int CDB_PORTS    = 2,
    parameter int COMMIT_WIDTH = 2
) (
    input logic       clk,
    input logic       rst,
    rob_multi_if.slave bus
);
    localparam int DEPTH = 2 ** TAG_WIDTH;
    typedef logic [TAG_WIDTH-1:0] tag_t;

    logic [DEPTH-1:0]                 valid_q, done_q;
    logic [DEPTH-1:0][4:0]            rd_q;
    logic [DEPTH-1:0][31:0]           pc_q;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q;

    tag_t               head_q, head_d, tail_q, tail_d;
    logic [TAG_WIDTH:0] count_q, count_d;

    logic [COMMIT_WIDTH-1:0]                 cvld_q, cvld_d;
    logic [COMMIT_WIDTH-1:0][4:0]            crd_q, crd_d;
    logic [COMMIT_WIDTH-1:0][31:0]           cpc_q, cpc_d;
    logic [COMMIT_WIDTH-1:0][DATA_WIDTH-1:0] cdata_q, cdata_d;

    logic                             full, alloc_fire;
    tag_t                             flush_off;
    tag_t [COMMIT_WIDTH-1:0]          slot_tag;
    logic [COMMIT_WIDTH-1:0]          elig;
    logic [TAG_WIDTH:0]               n_commit;
    logic [DEPTH-1:0]                 squash, commit_e, cdb_hit;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] cdb_dat;

    assign full       = (count_q == (TAG_WIDTH+1)'(DEPTH));
    assign alloc_fire = bus.alloc_valid && !full && !bus.flush && !bus.flush_all;
    // Age of the surviving youngest entry, measured from head.
    assign flush_off  = bus.flush_tag - head_q;

    for (genvar k = 0; k < COMMIT_WIDTH; k++) begin : g_slot
        assign slot_tag[k] = head_q + tag_t'(k);
    end

    // Retire slots form an unbroken run from head; a partial flush also caps
    // the run at flush_tag so squashed entries never retire.
    always_comb begin
        logic chain;
        chain    = 1'b1;
        elig     = '0;
        n_commit = '0;
        crd_d    = '0;
        cpc_d    = '0;
        cdata_d  = '0;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            chain = chain && valid_q[slot_tag[k]] && done_q[slot_tag[k]] &&
                    (!bus.flush || (k <= int'(flush_off)));
            elig[k] = chain;
            if (chain) begin
                n_commit   = n_commit + 1'b1;
                crd_d[k]   = rd_q[slot_tag[k]];
                cpc_d[k]   = pc_q[slot_tag[k]];
                cdata_d[k] = data_q[slot_tag[k]];
            end
        end
        cvld_d = bus.flush_all ? '0 : elig;
    end

    always_comb begin
        squash   = '0;
        commit_e = '0;
        cdb_hit  = '0;
        cdb_dat  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            squash[i] = bus.flush && valid_q[i] && (tag_t'(tag_t'(i) - head_q) > flush_off);
            for (int k = 0; k < COMMIT_WIDTH; k++)
                if (elig[k] && slot_tag[k] == tag_t'(i)) commit_e[i] = 1'b1;
            // Scan high to low so the lowest-numbered port wins on a tag clash.
            for (int p = CDB_PORTS - 1; p >= 0; p--) begin
                if (bus.cdb_valid[p] && bus.cdb_tag[p*TAG_WIDTH +: TAG_WIDTH] == tag_t'(i)) begin
                    cdb_hit[i] = 1'b1;
                    cdb_dat[i] = bus.cdb_data[p*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            cdb_hit[i] = cdb_hit[i] && valid_q[i] && !squash[i] && !bus.flush_all;
        end
    end

    always_comb begin
        head_d  = head_q + tag_t'(n_commit);
        tail_d  = tail_q;
        count_d = count_q - n_commit;
        if (bus.flush_all) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else if (bus.flush) begin
            tail_d  = bus.flush_tag + 1'b1;
            count_d = {1'b0, flush_off} + 1'b1 - n_commit;
        end else if (alloc_fire) begin
            tail_d  = tail_q + 1'b1;
            count_d = count_q + 1'b1 - n_commit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            done_q  <= '0;
            rd_q    <= '0;
            pc_q    <= '0;
            data_q  <= '0;
        end else if (bus.flush_all) begin
            valid_q <= '0;
            done_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (alloc_fire && tail_q == tag_t'(i)) begin
                    valid_q[i] <= 1'b1;
                    done_q[i]  <= 1'b0;
                    rd_q[i]    <= bus.alloc_rd;
                    pc_q[i]    <= bus.alloc_pc;
                end else if (commit_e[i] || squash[i]) begin
                    valid_q[i] <= 1'b0;
                    done_q[i]  <= 1'b0;
                end else if (cdb_hit[i]) begin
                    done_q[i] <= 1'b1;
                    data_q[i] <= cdb_dat[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            cvld_q  <= '0;
            crd_q   <= '0;
            cpc_q   <= '0;
            cdata_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            cvld_q  <= cvld_d;
            crd_q   <= crd_d;
            cpc_q   <= cpc_d;
            cdata_q <= cdata_d;
        end
    end

    assign bus.alloc_ready  = !full;
    assign bus.alloc_tag    = tail_q;
    assign bus.query_done   = valid_q[bus.query_tag] && done_q[bus.query_tag];
    assign bus.query_data   = data_q[bus.query_tag];
    assign bus.commit_valid = cvld_q;
    assign bus.commit_rd    = crd_q;
    assign bus.commit_pc    = cpc_q;
    assign bus.commit_data  = cdata_q;
    assign bus.rob_head     = head_q;
    assign bus.rob_tail     = tail_q;
    assign bus.rob_count    = count_q;
    assign bus.rob_full     = full;
    assign bus.rob_empty    = (count_q == '0);
endmodule

// File: tb/tb_rob_multi.sv
// Scoreboard bench for rob_multi: allocations queue expected retirements,
// the commit monitor pops and compares them in program order.
module tb_rob_multi;
    localparam int TW = 4, DW = 32, CP = 2, CW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rob_multi_if #(.TAG_WIDTH(TW), .DATA_WIDTH(DW), .CDB_PORTS(CP), .COMMIT_WIDTH(CW)) bus();
    rob_multi #(.TAG_WIDTH(TW), .DATA_WIDTH(DW), .CDB_PORTS(CP), .COMMIT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    typedef struct {
        logic [3:0]  tag;
        logic [4:0]  rd;
        logic [31:0] pc;
    } ent_t;

    ent_t        exp_q[$];
    logic [31:0] mdata[16];
    logic [3:0]  mtail;
    int checks = 0, errors = 0, ncommit = 0, ndual = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        ent_t e;
        if (bus.commit_valid == 2'b10) chk("slot_order", bus.commit_valid, 2'b01);
        if (bus.commit_valid == 2'b11) ndual++;
        for (int k = 0; k < CW; k++) begin
            if (bus.commit_valid[k]) begin
                ncommit++;
                if (exp_q.size() == 0) chk("commit_extra", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("commit_rd", bus.commit_rd[k*5 +: 5], e.rd);
                    chk("commit_pc", bus.commit_pc[k*32 +: 32], e.pc);
                    chk("commit_data", bus.commit_data[k*32 +: 32], mdata[e.tag]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
        mtail = '0;
    endtask

    task automatic do_alloc(input logic [4:0] rd, input logic [31:0] pc);
        chk("alloc_tag", bus.alloc_tag, mtail);
        bus.alloc_valid = 1'b1;
        bus.alloc_rd    = rd;
        bus.alloc_pc    = pc;
        exp_q.push_back('{tag: mtail, rd: rd, pc: pc});
        mtail = mtail + 1'b1;
        tick();
        bus.alloc_valid = 1'b0;
    endtask

    task automatic do_cdb(input logic [3:0] t, input logic [31:0] d);
        bus.cdb_valid      = 2'b01;
        bus.cdb_tag[3:0]   = t;
        bus.cdb_data[31:0] = d;
        mdata[t] = d;
        tick();
        bus.cdb_valid = '0;
    endtask

    task automatic do_cdb2(input logic [3:0] t0, input logic [31:0] d0,
                           input logic [3:0] t1, input logic [31:0] d1);
        bus.cdb_valid = 2'b11;
        bus.cdb_tag   = {t1, t0};
        bus.cdb_data  = {d1, d0};
        mdata[t1] = d1;
        mdata[t0] = d0;
        tick();
        bus.cdb_valid = '0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (!bus.rob_empty && n < 200) begin
            tick();
            n++;
        end
        if (!bus.rob_empty) chk(name, 0, 1);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c;
        logic [3:0] base;
        bus.alloc_valid = 0; bus.alloc_rd = 0; bus.alloc_pc = 0;
        bus.cdb_valid = 0; bus.cdb_tag = 0; bus.cdb_data = 0;
        bus.query_tag = 0; bus.flush = 0; bus.flush_tag = 0; bus.flush_all = 0;
        do_reset();

        chk("rst_empty", bus.rob_empty, 1);
        chk("rst_ready", bus.alloc_ready, 1);
        chk("rst_full", bus.rob_full, 0);
        chk("rst_count", bus.rob_count, 0);
        chk("rst_head", bus.rob_head, 0);
        chk("rst_tail", bus.rob_tail, 0);
        chk("rst_cvalid", bus.commit_valid, 0);

        // Two entries completed out of order retire together.
        do_alloc(5'd3, 32'h100);
        do_alloc(5'd5, 32'h104);
        chk("t1_count", bus.rob_count, 2);
        do_cdb(4'd1, 32'h28);
        do_cdb(4'd0, 32'h1E);
        chk("t1_latency", bus.commit_valid, 0);
        tick();
        chk("t1_dual", bus.commit_valid, 2'b11);
        chk("t1_rd0", bus.commit_rd[4:0], 3);
        chk("t1_rd1", bus.commit_rd[9:5], 5);
        chk("t1_data0", bus.commit_data[31:0], 32'h1E);
        chk("t1_data1", bus.commit_data[63:32], 32'h28);
        chk("t1_head", bus.rob_head, 2);
        tick();
        chk("t1_pulse", bus.commit_valid, 0);
        chk("t1_empty", bus.rob_empty, 1);

        // Younger completions wait for the head.
        base = mtail;
        for (int i = 0; i < 4; i++) do_alloc(5'(6 + i), 32'h200 + 32'(4 * i));
        c = ncommit;
        do_cdb(base + 4'd3, 32'h33);
        do_cdb(base + 4'd2, 32'h22);
        do_cdb(base + 4'd1, 32'h11);
        tick();
        tick();
        chk("t2_hold", ncommit - c, 0);
        chk("t2_count", bus.rob_count, 4);
        do_cdb(base, 32'h00);
        tick();
        chk("t2_pair0", bus.commit_valid, 2'b11);
        chk("t2_pc0", bus.commit_pc[31:0], 32'h200);
        tick();
        chk("t2_pair1", bus.commit_valid, 2'b11);
        tick();
        chk("t2_idle", bus.commit_valid, 0);
        chk("t2_empty", bus.rob_empty, 1);

        // Fill to capacity, reject an extra allocate, drain across the wrap.
        for (int i = 0; i < 16; i++) do_alloc(5'(i + 1), 32'h1000 + 32'(4 * i));
        chk("t3_full", bus.rob_full, 1);
        chk("t3_ready", bus.alloc_ready, 0);
        chk("t3_count", bus.rob_count, 16);
        bus.alloc_valid = 1'b1;
        bus.alloc_rd    = 5'd31;
        tick();
        bus.alloc_valid = 1'b0;
        chk("t3_tail_hold", bus.rob_tail, mtail);
        chk("t3_count_hold", bus.rob_count, 16);
        c = ndual;
        base = mtail;
        for (int j = 0; j < 8; j++)
            do_cdb2(base + 4'(2 * j), 32'hA000 + 32'(j), base + 4'(2 * j + 1), 32'hB000 + 32'(j));
        drain("t3_drain_timeout");
        chk("t3_duals", ndual - c, 8);
        chk("t3_empty", bus.rob_empty, 1);
        chk("t3_head", bus.rob_head, mtail);

        // Partial flush with a same-cycle CDB write to a squashed tag.
        do_reset();
        for (int i = 0; i < 6; i++) do_alloc(5'(10 + i), 32'h300 + 32'(4 * i));
        bus.flush         = 1'b1;
        bus.flush_tag     = 4'd2;
        bus.cdb_valid     = 2'b01;
        bus.cdb_tag[3:0]  = 4'd4;
        bus.cdb_data[31:0] = 32'h44;
        tick();
        bus.flush = 1'b0;
        bus.cdb_valid = '0;
        repeat (3) void'(exp_q.pop_back());
        mtail = 4'd3;
        chk("t4_tail", bus.rob_tail, 3);
        chk("t4_count", bus.rob_count, 3);
        bus.query_tag = 4'd4;
        #1;
        chk("t4_squashed_done", bus.query_done, 0);
        do_alloc(5'd20, 32'h400);
        bus.flush     = 1'b1;
        bus.flush_tag = 4'd3;
        tick();
        bus.flush = 1'b0;
        chk("t4_noop_tail", bus.rob_tail, 4);
        chk("t4_noop_count", bus.rob_count, 4);
        do_cdb(4'd1, 32'h111);
        bus.query_tag = 4'd1;
        #1;
        chk("t4_query_done", bus.query_done, 1);
        chk("t4_query_data", bus.query_data, 32'h111);
        do_cdb(4'd0, 32'h100);
        do_cdb(4'd2, 32'h122);
        do_cdb(4'd3, 32'h133);
        drain("t4_drain_timeout");

        // Both CDB ports hit the same tag; port 0 wins.
        base = mtail;
        do_alloc(5'd7, 32'h500);
        do_cdb2(base, 32'hAA, base, 32'hBB);
        bus.query_tag = base;
        #1;
        chk("t5_port0_wins", bus.query_data, 32'hAA);
        drain("t5_drain_timeout");

        // flush_all and reset both discard in-flight entries without commit.
        do_reset();
        for (int i = 0; i < 6; i++) do_alloc(5'(1 + i), 32'h600 + 32'(4 * i));
        do_cdb(4'd0, 32'h99);
        c = ncommit;
        bus.flush_all = 1'b1;
        tick();
        bus.flush_all = 1'b0;
        exp_q.delete();
        mtail = '0;
        chk("t6_cvalid", bus.commit_valid, 0);
        chk("t6_count", bus.rob_count, 0);
        chk("t6_head", bus.rob_head, 0);
        chk("t6_tail", bus.rob_tail, 0);
        tick();
        tick();
        chk("t6_no_commit", ncommit - c, 0);

        for (int i = 0; i < 3; i++) do_alloc(5'(1 + i), 32'h700 + 32'(4 * i));
        do_cdb(4'd0, 32'h77);
        c = ncommit;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        mtail = '0;
        chk("t6r_cvalid", bus.commit_valid, 0);
        chk("t6r_count", bus.rob_count, 0);
        chk("t6r_tail", bus.rob_tail, 0);
        tick();
        tick();
        chk("t6r_no_commit", ncommit - c, 0);
        chk("sb_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
